ssrv_mem_bridge: RTL and testbench
==================================

// Module: ssrv_mem_bridge
// PURPOSE
//  Parametrised bridge between the ssrv core's memory port and an SCR1 memory interface (req/req_ack/resp).
//  Supports up to OUTSTANDING pipelined requests, delivers responses in order, and applies core-side
//  back-pressure. Provides a flush that discards responses of in-flight requests, and optional read-data
//  lane alignment with sign/zero extension. One instance is used per port: imem (flush = redirect) and dmem.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width (power of 2, >=16)
//  OUTSTANDING 2   max accepted-but-undelivered requests (>=1); metadata/response FIFO depth
//  ALIGN_RDATA 1   1: shift rdata by addr[1:0] bytes, extend per width/unsigned; 0: pass rdata through
// PORTS
//  clk            in  1    clock
//  pipe_rst_n     in  1    asynchronous active-low reset
//  core_req       in  1    core request valid
//  core_gnt       out 1    request accepted this cycle (core_req & core_gnt)
//  core_cmd       in  1    0 read, 1 write
//  core_width     in  2    00 byte, 01 half, 10 word
//  core_unsigned  in  1    zero-extend sub-word read (ALIGN_RDATA=1 only)
//  core_addr      in  AW   byte address
//  core_wdata     in  DW   write data, passed unchanged
//  core_flush     in  1    discard responses of all requests accepted before this cycle
//  core_resp      out 1    response valid (head of response FIFO)
//  core_resp_rdy  in  1    core consumes response
//  core_rdata     out DW   read data (0 for writes)
//  core_err       out 1    response was SCR1_MEM_RESP_RDY_ER
//  mem_req        out 1    SCR1 request, held until mem_req_ack
//  mem_cmd        out type_scr1_mem_cmd_e    registered command
//  mem_width      out type_scr1_mem_width_e  registered width
//  mem_addr       out AW   registered address
//  mem_wdata      out DW   registered write data
//  mem_req_ack    in  1    request taken by memory
//  mem_rdata      in  DW   response data
//  mem_resp       in  type_scr1_mem_resp_e   IDLE / RDY_OK / RDY_ER
//  busy           out 1    occ != 0
//  proto_err      out 1    sticky: response with empty metadata FIFO
// BEHAVIOUR
//  Reset: mem_req=0, core_resp=0, busy=0, proto_err=0, occ=0, all FIFOs empty, req register invalid.
//  occ = requests accepted and neither delivered nor dropped; range 0..OUTSTANDING.
//  core_gnt = (~req_vld | mem_req_ack) & (occ < OUTSTANDING); combinational, no dependence on core_req.
//  Accept: load req register (cmd,width,addr,wdata,addr[1:0],unsigned); mem_req asserted next cycle.
//  mem_req = req_vld; mem_* fields stable while mem_req & ~mem_req_ack. Never withdrawn before ack.
//  mem_req & mem_req_ack: push metadata {cmd,width,lane,unsigned,drop} to meta FIFO; clear req_vld
//    unless a new request is accepted in the same cycle (back-to-back, one request per cycle).
//  mem_resp != IDLE: pop meta FIFO same cycle; drop=1 -> discard, occ--; else push {rdata',err} to resp FIFO.
//    Memory returns a response >=1 cycle after ack, so response/push and ack/push of the same
//    entry never coincide.
//  rdata': ALIGN_RDATA=1 & read -> (mem_rdata >> 8*lane), then sign- or zero-extend bit 7/15 per
//    width; word unchanged. Write -> 0. ALIGN_RDATA=0 -> mem_rdata for reads.
//  core_resp = resp FIFO not empty; pop and occ-- on core_resp & core_resp_rdy. Response FIFO
//    cannot overflow (occ bound).
//  core_flush: sets drop on every meta entry and on the req register (still issued, response
//    dropped); empties resp FIFO (occ -= its count, no core_resp next cycle). Requests accepted
//    in the flush cycle are not dropped. A mem response in the flush cycle is dropped.
//  Simultaneous decrements (pop, drop, flush) and increment (accept) are summed in one update;
//    occ width is clog2(OUTSTANDING+1).
//  mem_resp != IDLE with empty meta FIFO: ignored, proto_err<=1 until reset.
//  Reset mid-operation: all state cleared asynchronously; late memory responses set proto_err.
// TESTING
//  Single read word 0x1000, ack same cycle, RDY_OK 0xDEADBEEF 2 cycles later -> core_resp=1, rdata=0xDEADBEEF, err=0.
//  Byte read addr 0x1003 signed, rdata 0x80xxxxxx -> 0xFFFFFF80; unsigned -> 0x00000080; half addr 0x2 rdata 0x7FFF0000 -> 0x00007FFF.
//  OUTSTANDING=2, ack always 1, core_resp_rdy=0: 2 accepts, core_gnt=0 on the 3rd until one response is popped.
//  mem_req_ack low 5 cycles: mem_req and mem_addr stable; core_gnt=0; accept on ack cycle.
//  2 reads in flight, core_flush, then RDY_OK x2 -> no core_resp; 3rd request accepted in flush cycle -> delivered.
//  RDY_ER on write -> core_err=1, core_rdata=0; spurious RDY_OK while idle -> proto_err=1, stays 1.

Source files
------------

// File: rtl/ssrv_mem_bridge.sv
// rtl/ssrv_mem_bridge.sv - ssrv core memory port to SCR1 req/ack/resp bridge with in-order pipelined responses
package ssrv_mem_bridge_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE   = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module ssrv_mem_bridge
    import ssrv_mem_bridge_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 2,
    parameter int ALIGN_RDATA = 1
) (
    input  logic                 clk,
    input  logic                 pipe_rst_n,
    input  logic                 core_req,
    output logic                 core_gnt,
    input  logic                 core_cmd,
    input  logic [1:0]           core_width,
    input  logic                 core_unsigned,
    input  logic [AW-1:0]        core_addr,
    input  logic [DW-1:0]        core_wdata,
    input  logic                 core_flush,
    output logic                 core_resp,
    input  logic                 core_resp_rdy,
    output logic [DW-1:0]        core_rdata,
    output logic                 core_err,
    output logic                 mem_req,
    output type_scr1_mem_cmd_e   mem_cmd,
    output type_scr1_mem_width_e mem_width,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_req_ack,
    input  logic [DW-1:0]        mem_rdata,
    input  type_scr1_mem_resp_e  mem_resp,
    output logic                 busy,
    output logic                 proto_err
);
    localparam int OW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [OW-1:0] OCC_MAX  = OW'(OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

    typedef struct packed {
        type_scr1_mem_cmd_e   cmd;
        type_scr1_mem_width_e width;
        logic [1:0]           lane;
        logic                 uns;
    } meta_t;

    logic                 r_req_vld, r_drop, r_uns, r_proto_err;
    type_scr1_mem_cmd_e   r_cmd;
    type_scr1_mem_width_e r_width;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic [OW-1:0]        r_occ, r_mcnt, r_rcnt;
    meta_t                r_meta [OUTSTANDING];
    logic [OUTSTANDING-1:0] r_mdrop;
    logic [PW-1:0]        r_mwp, r_mrp, r_rwp, r_rrp;
    logic [DW:0]          r_resp [OUTSTANDING];

    logic          w_acc, w_issue, w_mresp, w_mpop, w_hd_drop, w_rpush, w_rdrop, w_rpop;
    meta_t         w_hd, w_min;
    logic [DW-1:0] w_rdata;
    logic [OW-1:0] w_rdec;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Byte lane shift followed by sign/zero extension of sub-word reads
    function automatic logic [DW-1:0] f_align(input logic [DW-1:0] d, input meta_t m);
        logic [DW-1:0] s;
        s = d >> {m.lane, 3'b000};
        case (m.width)
            SCR1_MEM_WIDTH_BYTE:  return m.uns ? {{(DW-8){1'b0}}, s[7:0]} : {{(DW-8){s[7]}}, s[7:0]};
            SCR1_MEM_WIDTH_HWORD: return m.uns ? {{(DW-16){1'b0}}, s[15:0]} : {{(DW-16){s[15]}}, s[15:0]};
            default:              return s;
        endcase
    endfunction

    assign core_gnt  = (~r_req_vld | mem_req_ack) & (r_occ < OCC_MAX);
    assign w_acc     = core_req & core_gnt;
    assign w_issue   = r_req_vld & mem_req_ack;
    assign w_mresp   = (mem_resp != SCR1_MEM_RESP_IDLE);
    assign w_mpop    = w_mresp & (r_mcnt != '0);
    assign w_hd      = r_meta[r_mrp];
    assign w_hd_drop = r_mdrop[r_mrp] | core_flush;
    assign w_rpush   = w_mpop & ~w_hd_drop;
    assign w_rdrop   = w_mpop & w_hd_drop;
    assign w_rpop    = core_resp & core_resp_rdy & ~core_flush;
    assign w_rdec    = core_flush ? r_rcnt : OW'(w_rpop);

    always_comb begin
        w_min       = '0;
        w_min.cmd   = r_cmd;
        w_min.width = r_width;
        w_min.lane  = r_addr[1:0];
        w_min.uns   = r_uns;
        if (w_hd.cmd == SCR1_MEM_CMD_WR) w_rdata = '0;
        else if (ALIGN_RDATA != 0)       w_rdata = f_align(mem_rdata, w_hd);
        else                             w_rdata = mem_rdata;
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_req_vld <= 1'b0;
            r_drop    <= 1'b0;
            r_cmd     <= SCR1_MEM_CMD_RD;
            r_width   <= SCR1_MEM_WIDTH_BYTE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_uns     <= 1'b0;
        end else if (w_acc) begin
            r_req_vld <= 1'b1;
            r_drop    <= 1'b0;
            r_cmd     <= type_scr1_mem_cmd_e'(core_cmd);
            r_width   <= type_scr1_mem_width_e'(core_width);
            r_addr    <= core_addr;
            r_wdata   <= core_wdata;
            r_uns     <= core_unsigned;
        end else begin
            if (w_issue)    r_req_vld <= 1'b0;
            if (core_flush) r_drop    <= 1'b1;
        end
    end

    // A request issued in the flush cycle was accepted earlier, so it is dropped too
    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_mdrop <= '0;
            r_mwp   <= '0;
            r_mrp   <= '0;
            r_mcnt  <= '0;
        end else begin
            if (core_flush) r_mdrop <= '1;
            if (w_issue) begin
                r_mdrop[r_mwp] <= r_drop | core_flush;
                r_mwp          <= f_inc(r_mwp);
            end
            if (w_mpop) r_mrp <= f_inc(r_mrp);
            r_mcnt <= r_mcnt + OW'(w_issue) - OW'(w_mpop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_meta[r_mwp] <= w_min;
        if (w_rpush) r_resp[r_rwp] <= {mem_resp == SCR1_MEM_RESP_RDY_ER, w_rdata};
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_rwp <= '0;
            r_rrp <= '0;
            r_rcnt <= '0;
        end else if (core_flush) begin
            r_rwp <= '0;
            r_rrp <= '0;
            r_rcnt <= '0;
        end else begin
            if (w_rpush) r_rwp <= f_inc(r_rwp);
            if (w_rpop)  r_rrp <= f_inc(r_rrp);
            r_rcnt <= r_rcnt + OW'(w_rpush) - OW'(w_rpop);
        end
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_occ       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_occ <= r_occ + OW'(w_acc) - w_rdec - OW'(w_rdrop);
            if (w_mresp && (r_mcnt == '0)) r_proto_err <= 1'b1;
        end
    end

    assign mem_req              = r_req_vld;
    assign mem_cmd              = r_cmd;
    assign mem_width            = r_width;
    assign mem_addr             = r_addr;
    assign mem_wdata            = r_wdata;
    assign core_resp            = (r_rcnt != '0);
    assign {core_err, core_rdata} = r_resp[r_rrp];
    assign busy                 = (r_occ != '0);
    assign proto_err            = r_proto_err;
endmodule

// File: tb/tb_ssrv_mem_bridge.sv
// tb/tb_ssrv_mem_bridge.sv - self-checking bench for ssrv_mem_bridge
module tb_ssrv_mem_bridge;
    import ssrv_mem_bridge_pkg::*;

    localparam int OUTS = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 core_req, core_gnt, core_cmd, core_unsigned, core_flush;
    logic [1:0]           core_width;
    logic [31:0]          core_addr, core_wdata, core_rdata, mem_addr, mem_wdata, mem_rdata;
    logic                 core_resp, core_resp_rdy, core_err, mem_req, mem_req_ack, busy, proto_err;
    type_scr1_mem_cmd_e   mem_cmd;
    type_scr1_mem_width_e mem_width;
    type_scr1_mem_resp_e  mem_resp;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic        cmd;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] wd;
        logic        u;
        bit          drop;
        int          rdy;
    } txn_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    txn_t pend[$];
    txn_t infl[$];
    rsp_t expq[$];

    always #5 clk = ~clk;

    ssrv_mem_bridge #(.AW(32), .DW(32), .OUTSTANDING(OUTS), .ALIGN_RDATA(1)) dut (
        .clk(clk), .pipe_rst_n(rst_n),
        .core_req(core_req), .core_gnt(core_gnt), .core_cmd(core_cmd), .core_width(core_width),
        .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_flush(core_flush), .core_resp(core_resp), .core_resp_rdy(core_resp_rdy),
        .core_rdata(core_rdata), .core_err(core_err),
        .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .busy(busy), .proto_err(proto_err)
    );

    function automatic logic [31:0] ref_rdata(input txn_t t, input logic [31:0] d);
        logic [31:0] v;
        if (t.cmd) return 32'h0;
        v = d >> (8 * t.a[1:0]);
        if (t.w == 2'd0) begin
            v = v % 256;
            if (!t.u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (t.w == 2'd1) begin
            v = v % 65536;
            if (!t.u && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        core_req = 0; core_cmd = 0; core_width = 2'd2; core_unsigned = 0;
        core_addr = 0; core_wdata = 0; core_flush = 0; core_resp_rdy = 0;
        mem_req_ack = 0; mem_rdata = 0; mem_resp = SCR1_MEM_RESP_IDLE;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0)   begin errs++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (core_resp !== 1'b0) begin errs++; $display("FAIL reset_core_resp: got %b expected 0", core_resp); end
        checks++; if (busy !== 1'b0)      begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
        checks++; if (core_gnt !== 1'b1)  begin errs++; $display("FAIL reset_core_gnt: got %b expected 1", core_gnt); end
        nxt();
    endtask

    task automatic test_single_txn();
        logic [31:0] t_addr [6];
        logic [31:0] t_data [6];
        logic [31:0] t_exp  [6];
        logic [1:0]  t_w    [6];
        logic        t_cmd  [6];
        logic        t_uns  [6];
        logic        t_er   [6];
        t_addr = '{32'h1000, 32'h1003, 32'h1003, 32'h0002, 32'h0006, 32'h2000};
        t_data = '{32'hDEADBEEF, 32'h80123456, 32'h80123456, 32'h7FFF0000, 32'h80011234, 32'h12345678};
        t_exp  = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'h00007FFF, 32'hFFFF8001, 32'h00000000};
        t_w    = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        t_cmd  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        t_uns  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t_er   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            core_req = 1; core_cmd = t_cmd[i]; core_width = t_w[i]; core_unsigned = t_uns[i];
            core_addr = t_addr[i]; core_wdata = 32'hCAFEF00D; mem_req_ack = 1;
            @(negedge clk);
            checks++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL single%0d_gnt: got %b expected 1", i, core_gnt); end
            nxt();
            core_req = 0;
            @(negedge clk);
            checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL single%0d_mem_req: got %b expected 1", i, mem_req); end
            checks++; if (mem_addr !== t_addr[i]) begin errs++; $display("FAIL single%0d_mem_addr: got %h expected %h", i, mem_addr, t_addr[i]); end
            checks++; if (mem_cmd !== type_scr1_mem_cmd_e'(t_cmd[i])) begin errs++; $display("FAIL single%0d_mem_cmd: got %b expected %b", i, mem_cmd, t_cmd[i]); end
            checks++; if (mem_width !== type_scr1_mem_width_e'(t_w[i])) begin errs++; $display("FAIL single%0d_mem_width: got %b expected %b", i, mem_width, t_w[i]); end
            if (t_cmd[i]) begin
                checks++; if (mem_wdata !== 32'hCAFEF00D) begin errs++; $display("FAIL single%0d_mem_wdata: got %h expected cafef00d", i, mem_wdata); end
            end
            nxt();
            nxt();
            mem_resp = t_er[i] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            mem_rdata = t_data[i];
            nxt();
            mem_resp = SCR1_MEM_RESP_IDLE;
            core_resp_rdy = 1;
            @(negedge clk);
            checks++; if (core_resp !== 1'b1) begin errs++; $display("FAIL single%0d_resp: got %b expected 1", i, core_resp); end
            checks++; if (core_rdata !== t_exp[i]) begin errs++; $display("FAIL single%0d_rdata: got %h expected %h", i, core_rdata, t_exp[i]); end
            checks++; if (core_err !== t_er[i]) begin errs++; $display("FAIL single%0d_err: got %b expected %b", i, core_err, t_er[i]); end
            nxt();
            core_resp_rdy = 0;
            @(negedge clk);
            checks++; if (core_resp !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL single%0d_drain: got resp=%b busy=%b expected 0/0", i, core_resp, busy); end
        end
        nxt();
    endtask

    task automatic test_outstanding();
        logic exp_g [7];
        exp_g = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        mem_req_ack = 1;
        for (int c = 0; c < 7; c++) begin
            core_req = 1; core_addr = 32'h100 + 32'(4 * c);
            mem_resp = SCR1_MEM_RESP_IDLE;
            if (c == 3) begin mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hA0A0A0A0; end
            if (c == 4) begin mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hB1B1B1B1; end
            core_resp_rdy = (c == 5);
            @(negedge clk);
            checks++; if (core_gnt !== exp_g[c]) begin errs++; $display("FAIL outst_gnt_c%0d: got %b expected %b", c, core_gnt, exp_g[c]); end
            if (c == 5) begin
                checks++; if (core_rdata !== 32'hA0A0A0A0 || core_resp !== 1'b1) begin errs++; $display("FAIL outst_first_rdata: got %h/%b expected a0a0a0a0/1", core_rdata, core_resp); end
            end
            if (c == 6) begin
                checks++; if (core_rdata !== 32'hB1B1B1B1 || core_resp !== 1'b1) begin errs++; $display("FAIL outst_second_rdata: got %h/%b expected b1b1b1b1/1", core_rdata, core_resp); end
            end
            nxt();
        end
        core_req = 0;
    endtask

    task automatic test_ack_stall();
        do_reset();
        core_req = 1; core_addr = 32'h3000; mem_req_ack = 0;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL stall_first_gnt: got %b expected 1", core_gnt); end
        nxt();
        core_addr = 32'h4000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin errs++; $display("FAIL stall_hold_c%0d: got req=%b addr=%h expected 1/3000", c, mem_req, mem_addr); end
            checks++; if (core_gnt !== 1'b0) begin errs++; $display("FAIL stall_gnt_c%0d: got %b expected 0", c, core_gnt); end
            nxt();
        end
        mem_req_ack = 1;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1 || mem_addr !== 32'h3000) begin errs++; $display("FAIL stall_ack_cycle: got gnt=%b addr=%h expected 1/3000", core_gnt, mem_addr); end
        nxt();
        mem_req_ack = 0; core_req = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin errs++; $display("FAIL stall_b2b: got req=%b addr=%h expected 1/4000", mem_req, mem_addr); end
        nxt();
    endtask

    task automatic test_flush();
        do_reset();
        mem_req_ack = 1; core_resp_rdy = 1;
        core_req = 1; core_addr = 32'h100;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL flush_gnt0: got %b expected 1", core_gnt); end
        nxt();
        core_addr = 32'h104;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL flush_gnt1: got %b expected 1", core_gnt); end
        nxt();
        core_req = 0; core_flush = 1;
        nxt();
        core_flush = 0;
        for (int c = 0; c < 3; c++) begin
            mem_resp = (c < 2) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_IDLE;
            mem_rdata = 32'h11111111 * 32'(c + 1);
            @(negedge clk);
            checks++; if (core_resp !== 1'b0) begin errs++; $display("FAIL flush_dropped_c%0d: got core_resp=%b expected 0", c, core_resp); end
            nxt();
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b expected 0", busy); end
        nxt();
        core_req = 1; core_addr = 32'h200;
        nxt();
        core_req = 0;
        nxt();
        core_req = 1; core_addr = 32'h300; core_flush = 1;
        @(negedge clk);
        checks++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL flush_cycle_gnt: got %b expected 1", core_gnt); end
        nxt();
        core_req = 0; core_flush = 0;
        for (int c = 0; c < 3; c++) begin
            mem_resp = (c != 1) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_IDLE;
            mem_rdata = (c == 0) ? 32'h33333333 : 32'h44444444;
            @(negedge clk);
            checks++; if (core_resp !== 1'b0) begin errs++; $display("FAIL flush_partb_c%0d: got core_resp=%b expected 0", c, core_resp); end
            nxt();
        end
        mem_resp = SCR1_MEM_RESP_IDLE;
        @(negedge clk);
        checks++; if (core_resp !== 1'b1 || core_rdata !== 32'h44444444) begin errs++; $display("FAIL flush_survivor: got %b/%h expected 1/44444444", core_resp, core_rdata); end
        nxt();
        @(negedge clk);
        checks++; if (core_resp !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL flush_end: got resp=%b busy=%b expected 0/0", core_resp, busy); end
        nxt();
    endtask

    task automatic test_proto_err();
        do_reset();
        mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL proto_before: got %b expected 0", proto_err); end
        nxt();
        mem_resp = SCR1_MEM_RESP_IDLE;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (proto_err !== 1'b1 || core_resp !== 1'b0) begin errs++; $display("FAIL proto_sticky_c%0d: got perr=%b resp=%b expected 1/0", c, proto_err, core_resp); end
            nxt();
        end
        do_reset();
        core_req = 1; core_addr = 32'h500; mem_req_ack = 1;
        nxt();
        core_req = 0;
        nxt();
        rst_n = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL midreset_clear: got req=%b busy=%b expected 0/0", mem_req, busy); end
        nxt();
        rst_n = 1; mem_resp = SCR1_MEM_RESP_RDY_OK;
        nxt();
        mem_resp = SCR1_MEM_RESP_IDLE;
        @(negedge clk);
        checks++; if (proto_err !== 1'b1 || core_resp !== 1'b0) begin errs++; $display("FAIL midreset_late_resp: got perr=%b resp=%b expected 1/0", proto_err, core_resp); end
        nxt();
    endtask

    task automatic test_random();
        int   cyc;
        int   occ;
        logic exp_g;
        logic fl;
        txn_t t;
        rsp_t r;
        do_reset();
        pend.delete(); infl.delete(); expq.delete();
        for (cyc = 1; cyc <= 600; cyc++) begin
            core_req      = ($urandom_range(0, 2) != 0);
            core_cmd      = 1'($urandom_range(0, 1));
            core_width    = 2'($urandom_range(0, 2));
            core_unsigned = 1'($urandom_range(0, 1));
            core_addr     = $urandom();
            core_wdata    = $urandom();
            core_resp_rdy = ($urandom_range(0, 3) != 0);
            core_flush    = ($urandom_range(0, 24) == 0);
            mem_req_ack   = ($urandom_range(0, 3) != 0);
            mem_rdata     = $urandom();
            mem_resp      = SCR1_MEM_RESP_IDLE;
            if (infl.size() > 0 && infl[0].rdy <= cyc && $urandom_range(0, 3) != 0)
                mem_resp = ($urandom_range(0, 3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            @(negedge clk);
            occ   = pend.size() + infl.size() + expq.size();
            exp_g = (pend.size() == 0 || mem_req_ack) && (occ < OUTS);
            checks++; if (core_gnt !== exp_g) begin errs++; $display("FAIL rand_gnt cyc%0d: got %b expected %b", cyc, core_gnt, exp_g); end
            checks++; if (mem_req !== (pend.size() > 0)) begin errs++; $display("FAIL rand_mem_req cyc%0d: got %b expected %b", cyc, mem_req, pend.size() > 0); end
            if (pend.size() > 0) begin
                checks++; if (mem_addr !== pend[0].a || mem_cmd !== type_scr1_mem_cmd_e'(pend[0].cmd)) begin errs++; $display("FAIL rand_mem_fields cyc%0d: got %h/%b expected %h/%b", cyc, mem_addr, mem_cmd, pend[0].a, pend[0].cmd); end
            end
            checks++; if (core_resp !== (expq.size() > 0)) begin errs++; $display("FAIL rand_core_resp cyc%0d: got %b expected %b", cyc, core_resp, expq.size() > 0); end
            if (expq.size() > 0) begin
                checks++; if (core_rdata !== expq[0].d || core_err !== expq[0].e) begin errs++; $display("FAIL rand_rdata cyc%0d: got %h/%b expected %h/%b", cyc, core_rdata, core_err, expq[0].d, expq[0].e); end
            end
            checks++; if (busy !== (occ != 0)) begin errs++; $display("FAIL rand_busy cyc%0d: got %b expected %b", cyc, busy, occ != 0); end
            fl = core_flush;
            if (fl) expq.delete();
            else if (expq.size() > 0 && core_resp_rdy) void'(expq.pop_front());
            if (mem_resp != SCR1_MEM_RESP_IDLE) begin
                t = infl.pop_front();
                if (!(t.drop || fl)) begin
                    r.d = ref_rdata(t, mem_rdata);
                    r.e = (mem_resp == SCR1_MEM_RESP_RDY_ER);
                    expq.push_back(r);
                end
            end
            if (pend.size() > 0 && mem_req_ack) begin
                t = pend.pop_front();
                t.rdy = cyc + int'($urandom_range(1, 3));
                if (infl.size() > 0 && t.rdy < infl[$].rdy) t.rdy = infl[$].rdy;
                infl.push_back(t);
            end
            if (fl) begin
                foreach (infl[i]) infl[i].drop = 1'b1;
                foreach (pend[i]) pend[i].drop = 1'b1;
            end
            if (core_req && exp_g) begin
                t.cmd = core_cmd; t.w = core_width; t.a = core_addr; t.wd = core_wdata;
                t.u = core_unsigned; t.drop = 1'b0; t.rdy = 0;
                pend.push_back(t);
            end
            nxt();
        end
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL rand_proto_err: got %b expected 0", proto_err); end
        nxt();
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        test_reset();
        test_single_txn();
        test_outstanding();
        test_ack_stall();
        test_flush();
        test_proto_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
